// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the 10011 stream controller and the detector it drives.
package seq_ctrl_pkg;

    localparam int unsigned CTRL_ST_W = 3;
    localparam int unsigned DET_ST_W  = 5;

    typedef enum logic [CTRL_ST_W-1:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } ctrl_state_e;

    // Detector one-hot states: A none, B "1", C "10", D "100", E "1001".
    typedef enum logic [DET_ST_W-1:0] {
        DET_A = 5'b00001,
        DET_B = 5'b00010,
        DET_C = 5'b00100,
        DET_D = 5'b01000,
        DET_E = 5'b10000
    } det_state_e;

endpackage

// File: rtl/ser_shift.sv
// Loadable shift register presenting one registered head bit per cycle.
module ser_shift #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // Load wins over shift so a back-to-back reload never loses the new word.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign head_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/seq_detect_ctrl.sv
// Feeds parallel words bit-serially into a 10011 detector, gating its reset
// so context survives only across back-to-back words, and counts matches.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             det_in,
    output logic             det_rst_n,
    input  logic             det_out,
    input  logic             clear,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             gap,
    output logic             done
);

    localparam int unsigned       BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(WIDTH - 1);

    ctrl_state_e      state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             last_q, last_d;
    logic             in_ready_q, in_ready_d;
    logic             gap_q, gap_d;
    logic             done_q, done_d;
    logic             match_pulse_q, match_pulse_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             load, shift;

    ser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (in_data),
        .head_o  (det_in)
    );

    // Next state, word acceptance and one-cycle status pulses.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        load      = 1'b0;
        shift     = 1'b0;
        gap_d     = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    last_d    = in_last;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift     = 1'b1;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (in_valid) begin
                        load   = 1'b1;
                        last_d = in_last;
                    end else begin
                        gap_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is precomputed from next state so it leaves the block registered.
    always_comb begin
        in_ready_d = (state_d == IDLE) ||
                     ((state_d == SHIFT) && (bit_cnt_d == LAST_BIT) && !last_d);
    end

    always_comb begin
        match_pulse_d = det_out && (state_q == SHIFT);
        match_count_d = match_count_q;
        if (clear) begin
            match_count_d = '0;
        end else if (match_pulse_q && !(&match_count_q)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            last_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            gap_q         <= 1'b0;
            done_q        <= 1'b0;
            match_pulse_q <= 1'b0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            last_q        <= last_d;
            in_ready_q    <= in_ready_d;
            gap_q         <= gap_d;
            done_q        <= done_d;
            match_pulse_q <= match_pulse_d;
            match_count_q <= match_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign gap         = gap_q;
    assign done        = done_q;
    assign match_pulse = match_pulse_q;
    assign match_count = match_count_q;
    assign det_rst_n   = reset && (state_q == SHIFT);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench: controller plus a behavioural 10011 detector; a second
// instance with a 2-bit counter shares the stimulus to observe saturation.
module tb_seq_detect_ctrl;
    import seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        clear;

    logic        in_ready, det_in, det_rst_n, det_out, match_pulse, gap, done;
    logic [15:0] match_count;
    logic        s_in_ready, s_det_in, s_det_rst_n, s_det_out, s_match_pulse, s_gap, s_done;
    logic [1:0]  s_match_count;

    logic [4:0]  det_q, s_det_q;
    logic [5:0]  det_nx, s_det_nx;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WIDTH(8), .CNT_W(16), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .det_in(det_in), .det_rst_n(det_rst_n),
        .det_out(det_out), .clear(clear), .match_pulse(match_pulse),
        .match_count(match_count), .gap(gap), .done(done)
    );

    seq_detect_ctrl #(.WIDTH(8), .CNT_W(2), .MSB_FIRST(1'b1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .det_in(s_det_in), .det_rst_n(s_det_rst_n),
        .det_out(s_det_out), .clear(clear), .match_pulse(s_match_pulse),
        .match_count(s_match_count), .gap(s_gap), .done(s_done)
    );

    // Mealy 10011 detector step: returns {match, next_state}.
    function automatic logic [5:0] det_step(input logic [4:0] s, input logic b);
        case (s)
            DET_A:   det_step = {1'b0, b ? DET_B : DET_A};
            DET_B:   det_step = {1'b0, b ? DET_B : DET_C};
            DET_C:   det_step = {1'b0, b ? DET_B : DET_D};
            DET_D:   det_step = {1'b0, b ? DET_E : DET_A};
            DET_E:   det_step = b ? {1'b1, DET_B} : {1'b0, DET_C};
            default: det_step = {1'b0, DET_A};
        endcase
    endfunction

    assign det_nx    = det_step(det_q, det_in);
    assign det_out   = det_nx[5];
    assign s_det_nx  = det_step(s_det_q, s_det_in);
    assign s_det_out = s_det_nx[5];

    always_ff @(posedge clk) begin
        if (!det_rst_n) det_q <= DET_A;
        else            det_q <= det_nx[4:0];
        if (!s_det_rst_n) s_det_q <= DET_A;
        else              s_det_q <= s_det_nx[4:0];
    end

    // Negedge monitor: snapshot of the cycle plus event counters.
    int          cyc_n = 0;
    logic [5:0]  snap;
    logic [15:0] snap_cnt;
    logic [1:0]  snap_scnt;
    int          gap_n = 0, done_n = 0, rstlow_n = 0, smp_n = 0;
    int          mp_cyc[$];

    always @(negedge clk) begin
        cyc_n++;
        snap      = {in_ready, det_in, det_rst_n, match_pulse, done, gap};
        snap_cnt  = match_count;
        snap_scnt = s_match_count;
        if (match_pulse === 1'b1) mp_cyc.push_back(cyc_n);
        if (s_match_pulse === 1'b1) smp_n++;
        if (gap === 1'b1) gap_n++;
        if (done === 1'b1) done_n++;
        if (det_rst_n === 1'b0) rstlow_n++;
    end

    int pass_n = 0, total_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle's inputs; returns after the monitor has sampled that cycle.
    task automatic step(input logic v, input logic l, input logic [7:0] d, input logic clr);
        in_valid = v; in_last = l; in_data = d; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_all();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        mp_cyc.delete();
        gap_n = 0; done_n = 0; rstlow_n = 0; smp_n = 0;
    endtask

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic [5:0] exp; // {in_ready, det_in, det_rst_n, match_pulse, done, gap}
    } vec_t;

    vec_t vecs[11];
    int   base;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h98, 6'b100000};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 6'b011000};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 6'b001000};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 6'b001000};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 6'b011000};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 6'b011000};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 6'b001100};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 6'b001000};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 6'b001000};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 6'b000010};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 6'b100000};

        reset = 1'b0;
        idle(2);
        check("reset_outputs", 32'(snap), 32'(6'b100000));
        check("reset_count", 32'(snap_cnt), 0);
        check("reset_sat_count", 32'(snap_scnt), 0);
        reset = 1'b1;
        idle(1);
        check("idle_after_reset", 32'(snap), 32'(6'b100000));

        // Single last word 1001_1000
        clear_all();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].v, vecs[i].l, vecs[i].d, 1'b0);
            check($sformatf("single[%0d]", i), 32'(snap), 32'(vecs[i].exp));
        end
        check("single_count", 32'(snap_cnt), 1);

        // Cross-boundary match, back-to-back words
        clear_all();
        base = cyc_n + 1;
        step(1'b1, 1'b0, 8'h04, 1'b0);
        rstlow_n = 0;
        idle(7);
        step(1'b1, 1'b1, 8'hC0, 1'b0);
        check("xb_ready_bit7", 32'(snap[5]), 1);
        idle(8);
        check("xb_no_bubble", 32'(rstlow_n), 0);
        idle(2);
        check("xb_match_n", 32'(mp_cyc.size()), 1);
        check("xb_match_cyc", (mp_cyc.size() > 0) ? 32'(mp_cyc[0] - base) : 32'hFFFF_FFFF, 11);
        check("xb_done_n", 32'(done_n), 1);
        check("xb_count", 32'(snap_cnt), 1);

        // Broken stream: second word one cycle late
        clear_all();
        step(1'b1, 1'b0, 8'h04, 1'b0);
        rstlow_n = 0;
        idle(8);
        step(1'b1, 1'b1, 8'hC0, 1'b0);
        check("brk_gap_cycle", 32'(snap[0]), 1);
        idle(8);
        check("brk_rst_low", 32'(rstlow_n), 1);
        idle(2);
        check("brk_gap_n", 32'(gap_n), 1);
        check("brk_match_n", 32'(mp_cyc.size()), 0);
        check("brk_count", 32'(snap_cnt), 0);

        // Overlapping matches
        clear_all();
        base = cyc_n + 1;
        step(1'b1, 1'b0, 8'h99, 1'b0);
        idle(7);
        step(1'b1, 1'b1, 8'h80, 1'b0);
        idle(10);
        check("ov_match_n", 32'(mp_cyc.size()), 2);
        check("ov_first", (mp_cyc.size() > 0) ? 32'(mp_cyc[0] - base) : 32'hFFFF_FFFF, 6);
        check("ov_second", (mp_cyc.size() > 1) ? 32'(mp_cyc[1] - base) : 32'hFFFF_FFFF, 10);
        check("ov_count", 32'(snap_cnt), 2);
        check("ov_done_n", 32'(done_n), 1);

        // Five matches: wide counter reaches 5, 2-bit counter saturates at 3
        clear_all();
        step(1'b1, 1'b0, 8'h99, 1'b0);
        idle(7);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        idle(7);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        idle(10);
        check("sat_match_n", 32'(mp_cyc.size()), 5);
        check("sat_s_match_n", 32'(smp_n), 5);
        check("sat_wide_count", 32'(snap_cnt), 5);
        check("sat_count", 32'(snap_scnt), 3);

        // Clear in the same cycle as a match pulse
        step(1'b1, 1'b1, 8'h98, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_pulse_seen", 32'(snap[2]), 1);
        check("clr_wide_before", 32'(snap_cnt), 5);
        check("clr_sat_before", 32'(snap_scnt), 3);
        idle(1);
        check("clr_wide_after", 32'(snap_cnt), 0);
        check("clr_sat_after", 32'(snap_scnt), 0);
        idle(4);

        // Reset mid-word: no done or gap afterwards
        step(1'b1, 1'b1, 8'h98, 1'b0);
        idle(2);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        done_n = 0; gap_n = 0;
        idle(12);
        check("rst_mid_done", 32'(done_n), 0);
        check("rst_mid_gap", 32'(gap_n), 0);
        check("rst_mid_idle", 32'(snap), 32'(6'b100000));

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
